// File: rtl/apb_initiator.sv
// apb_initiator: single-outstanding APB3 requester.
// Core valid/ready request/response in, APB setup/access transfers out.
module apb_initiator #(
    parameter int W_ADDR  = 16,
    parameter int W_DATA  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [W_ADDR-1:0] req_addr,
    input  logic [W_DATA-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W_DATA-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [W_ADDR-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [W_DATA-1:0] pwdata,
    input  logic [W_DATA-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int W_CNT = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t            state, state_d;
    logic [W_CNT-1:0]  cnt, cnt_d;
    logic [W_ADDR-1:0] paddr_d;
    logic [W_DATA-1:0] pwdata_d, rsp_rdata_d;
    logic              psel_d, penable_d, pwrite_d;
    logic              rsp_valid_d, rsp_err_d;
    logic              tmo_hit;

    // The cycle being evaluated is the TIMEOUT-th ACCESS cycle without pready.
    assign tmo_hit   = (TIMEOUT != 0) && (int'(cnt) == TIMEOUT - 1);
    assign req_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            paddr     <= '0;
            pwdata    <= '0;
            pwrite    <= 1'b0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            paddr     <= paddr_d;
            pwdata    <= pwdata_d;
            pwrite    <= pwrite_d;
            psel      <= psel_d;
            penable   <= penable_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        paddr_d     = paddr;
        pwdata_d    = pwdata;
        pwrite_d    = pwrite;
        psel_d      = psel;
        penable_d   = penable;
        rsp_valid_d = rsp_valid;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    paddr_d  = req_addr;
                    pwdata_d = req_wdata;
                    pwrite_d = req_write;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    rsp_rdata_d = pwrite ? '0 : prdata;
                    rsp_err_d   = pslverr;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (tmo_hit) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt + W_CNT'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_apb_initiator.sv
// tb_apb_initiator: directed transfers against a transaction-level model
// of the requester, plus hand-computed latency and data expectations.
module tb_apb_initiator;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;

    apb_initiator #(
        .W_ADDR (16),
        .W_DATA (32),
        .TIMEOUT(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .paddr    (paddr),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit armed = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    // Transaction-level model: a transfer is "in flight" for some number of
    // cycles (age 1 = setup, age k+1 = k-th access cycle), then "responding".
    bit          m_busy = 1'b0;
    bit          m_resp = 1'b0;
    int          m_age  = 0;
    logic [15:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_rd = '0;
    bit          m_wr = 1'b0;
    bit          m_er = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_resp <= 1'b0;
            m_age  <= 0;
            m_rd   <= '0;
            m_er   <= 1'b0;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy  <= 1'b1;
                m_age   <= 1;
                m_addr  <= req_addr;
                m_wdata <= req_wdata;
                m_wr    <= req_write;
            end
        end else if (!m_resp) begin
            if (m_age >= 2 && pready) begin
                m_resp <= 1'b1;
                m_rd   <= m_wr ? 32'd0 : prdata;
                m_er   <= pslverr;
            end else if (m_age >= 2 && m_age - 1 == TMO) begin
                m_resp <= 1'b1;
                m_rd   <= 32'd0;
                m_er   <= 1'b1;
            end else begin
                m_age <= m_age + 1;
            end
        end else if (rsp_ready) begin
            m_busy <= 1'b0;
            m_resp <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("m_req_ready", 32'(req_ready), 32'(!m_busy));
            chk("m_psel", 32'(psel), 32'(m_busy && !m_resp));
            chk("m_penable", 32'(penable), 32'(m_busy && !m_resp && m_age >= 2));
            chk("m_rsp_valid", 32'(rsp_valid), 32'(m_resp));
            if (m_busy && !m_resp) begin
                chk("m_paddr", 32'(paddr), 32'(m_addr));
                chk("m_pwrite", 32'(pwrite), 32'(m_wr));
                chk("m_pwdata", pwdata, m_wdata);
            end
            if (m_resp) begin
                chk("m_rsp_rdata", rsp_rdata, m_rd);
                chk("m_rsp_err", 32'(rsp_err), 32'(m_er));
            end
        end
    end

    task automatic txn(input bit wr, input logic [15:0] addr,
                       input logic [31:0] wd, input int waits, input bit tmo,
                       input logic [31:0] rd, input bit er, input int hold,
                       input bit keep_req, input int lat,
                       input logic [31:0] exp_rd, input bit exp_er);
        int t;
        int n;
        bit last;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        chk("idle_ready", 32'(req_ready), 32'd1);
        chk("idle_psel", 32'(psel), 32'd0);
        t = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        req_write = !wr;
        req_addr  = ~addr;
        req_wdata = ~wd;
        chk("setup_psel", 32'(psel), 32'd1);
        chk("setup_pen", 32'(penable), 32'd0);
        n = tmo ? TMO : waits + 1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            last    = !tmo && (i == waits);
            pready  = last;
            prdata  = last ? rd : 32'hDEAD0000 + 32'(i);
            pslverr = last ? er : 1'b1;
            chk("acc_pen", 32'(penable), 32'd1);
            chk("acc_addr", 32'(paddr), 32'(addr));
            if (wr) chk("acc_wdata", pwdata, wd);
        end
        @(negedge clk);
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = '0;
        chk("rsp_lat", 32'(cyc - t), 32'(lat));
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", 32'(rsp_err), 32'(exp_er));
        chk("rsp_psel", 32'(psel), 32'd0);
        if (keep_req) begin
            req_valid = 1'b1;
            req_write = 1'b0;
            req_addr  = 16'h0020;
            req_wdata = '0;
        end
        rsp_ready = (hold == 0);
        for (int k = 1; k <= hold; k++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rdata", rsp_rdata, exp_rd);
            chk("hold_ready", 32'(req_ready), 32'd0);
            chk("hold_psel", 32'(psel), 32'd0);
            if (k == hold) rsp_ready = 1'b1;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        armed = 1'b1;
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_pen", 32'(penable), 32'd0);
        chk("rst_pwrite", 32'(pwrite), 32'd0);
        chk("rst_paddr", 32'(paddr), 32'd0);
        chk("rst_pwdata", pwdata, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        txn(1'b0, 16'h0008, 32'h0, 0, 1'b0, 32'h12345678, 1'b0,
            0, 1'b0, 3, 32'h12345678, 1'b0);
        txn(1'b1, 16'h0010, 32'hA5A5A5A5, 1, 1'b0, 32'hFFFFFFFF, 1'b0,
            0, 1'b0, 4, 32'h0, 1'b0);
        txn(1'b0, 16'h0004, 32'h0, 3, 1'b0, 32'h0BADBEEF, 1'b1,
            0, 1'b0, 6, 32'h0BADBEEF, 1'b1);
        txn(1'b0, 16'h000C, 32'h0, 0, 1'b1, 32'h0, 1'b0,
            0, 1'b0, 6, 32'h0, 1'b1);
        txn(1'b0, 16'h0018, 32'h0, 0, 1'b0, 32'h55AA55AA, 1'b0,
            5, 1'b1, 3, 32'h55AA55AA, 1'b0);
        txn(1'b0, 16'h0020, 32'h0, 0, 1'b0, 32'h01020304, 1'b0,
            0, 1'b0, 3, 32'h01020304, 1'b0);

        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'h0030;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_pen", 32'(penable), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_psel", 32'(psel), 32'd0);
        chk("mid_rst_pen", 32'(penable), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;

        txn(1'b0, 16'h0034, 32'h0, 0, 1'b0, 32'hCAFEF00D, 1'b0,
            0, 1'b0, 3, 32'hCAFEF00D, 1'b0);
        @(negedge clk);
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
